// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write bypass, optional registered read, zero register and clear sweep
module reg_file_mp #(
  parameter int DATA_WIDTH   = 8,
  parameter int REG_WIDTH    = 3,
  parameter int NUM_READ     = 2,
  parameter int NUM_WRITE    = 2,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_WRITE-1:0]            write_en,
  input  logic [NUM_WRITE*REG_WIDTH-1:0]  write_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_READ*REG_WIDTH-1:0]   read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  read_data,
  input  logic                            clear_req,
  output logic                            clear_busy
);
  localparam int DEPTH = 1 << REG_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [REG_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_WRITE-1:0] wr_ok;
  logic [NUM_READ*DATA_WIDTH-1:0] lookup;
  logic last;
  assign clear_busy = state == CLEAR;
  assign last = cnt == '1;
  // A write is live only when not sweeping and not aimed at a hard-wired zero entry
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NUM_WRITE; i++)
      wr_ok[i] = write_en[i] && !clear_busy &&
                 !(ZERO_REG != 0 && write_addr[i*REG_WIDTH +: REG_WIDTH] == '0);
  end
  // Ascending port scan so the highest-index matching writer is forwarded
  always_comb begin
    lookup = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      lookup[j*DATA_WIDTH +: DATA_WIDTH] = mem[read_addr[j*REG_WIDTH +: REG_WIDTH]];
      for (int i = 0; i < NUM_WRITE; i++)
        if (BYPASS != 0 && wr_ok[i] &&
            write_addr[i*REG_WIDTH +: REG_WIDTH] == read_addr[j*REG_WIDTH +: REG_WIDTH])
          lookup[j*DATA_WIDTH +: DATA_WIDTH] = write_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (ZERO_REG != 0 && read_addr[j*REG_WIDTH +: REG_WIDTH] == '0)
        lookup[j*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
  always_comb begin
    state_nxt = clear_busy ? (last ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
    cnt_nxt   = (clear_busy && !last) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  // Later ports overwrite earlier ones on the same address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else if (clear_busy) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NUM_WRITE; i++)
        if (wr_ok[i]) mem[write_addr[i*REG_WIDTH +: REG_WIDTH]] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  if (READ_LATENCY != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) read_data <= '0;
      else        read_data <= lookup;
  end else begin : g_comb
    assign read_data = lookup;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: four configurations driven in lockstep, checked against hand-derived vectors and a latency queue
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  we;
  logic [5:0]  wa;
  logic [15:0] wd;
  logic [5:0]  ra;
  logic        clr;
  logic [15:0] rd_d, rd_nb, rd_l, rd_z;
  logic        bz_d, bz_nb, bz_l, bz_z;
  reg_file_mp dut_d (.clk(clk), .rst_n(rst_n), .write_en(we), .write_addr(wa), .write_data(wd),
    .read_addr(ra), .read_data(rd_d), .clear_req(clr), .clear_busy(bz_d));
  reg_file_mp #(.BYPASS(0)) dut_nb (.clk(clk), .rst_n(rst_n), .write_en(we), .write_addr(wa),
    .write_data(wd), .read_addr(ra), .read_data(rd_nb), .clear_req(clr), .clear_busy(bz_nb));
  reg_file_mp #(.READ_LATENCY(1)) dut_l (.clk(clk), .rst_n(rst_n), .write_en(we), .write_addr(wa),
    .write_data(wd), .read_addr(ra), .read_data(rd_l), .clear_req(clr), .clear_busy(bz_l));
  reg_file_mp #(.ZERO_REG(1)) dut_z (.clk(clk), .rst_n(rst_n), .write_en(we), .write_addr(wa),
    .write_data(wd), .read_addr(ra), .read_data(rd_z), .clear_req(clr), .clear_busy(bz_z));
  int total = 0;
  int passed = 0;
  logic [7:0] lat_q[$];
  typedef struct {
    logic [1:0] we;
    logic [2:0] wa0, wa1;
    logic [7:0] wd0, wd1;
    logic [2:0] ra0, ra1;
    logic [7:0] d0, d1, nb0, l0, z0;
  } vec_t;
  vec_t vecs[11];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic [1:0] e, input logic [2:0] a0, input logic [2:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [2:0] r0, input logic [2:0] r1, input logic c);
    @(negedge clk);
    we = e; wa = {a1, a0}; wd = {d1, d0}; ra = {r1, r0}; clr = c;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    vecs[0]  = '{2'b01, 3'd1, 3'd0, 8'h5A, 8'h00, 3'd1, 3'd0, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vecs[1]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd1, 3'd0, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'h5A};
    vecs[2]  = '{2'b11, 3'd3, 3'd3, 8'h11, 8'h22, 3'd3, 3'd1, 8'h22, 8'h5A, 8'h00, 8'h22, 8'h22};
    vecs[3]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd3, 3'd2, 8'h22, 8'h00, 8'h22, 8'h22, 8'h22};
    vecs[4]  = '{2'b01, 3'd2, 3'd0, 8'h77, 8'h00, 3'd2, 3'd3, 8'h77, 8'h22, 8'h00, 8'h77, 8'h77};
    vecs[5]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd2, 3'd2, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
    vecs[6]  = '{2'b10, 3'd0, 3'd0, 8'h00, 8'hAB, 3'd0, 3'd2, 8'hAB, 8'h77, 8'h00, 8'hAB, 8'h00};
    vecs[7]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd1, 8'hAB, 8'h5A, 8'hAB, 8'hAB, 8'h00};
    vecs[8]  = '{2'b11, 3'd4, 3'd4, 8'hC3, 8'h3C, 3'd4, 3'd4, 8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C};
    vecs[9]  = '{2'b01, 3'd7, 3'd6, 8'h99, 8'h55, 3'd6, 3'd7, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd7, 3'd6, 8'h99, 8'h00, 8'h99, 8'h99, 8'h99};
    we = '0; wa = '0; wd = '0; ra = '0; clr = 1'b0;
    #7;
    check("reset busy", {7'd0, bz_d}, 8'h00);
    check("reset lat rd", rd_l[7:0], 8'h00);
    check("reset rd", rd_d[15:8], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].we, vecs[k].wa0, vecs[k].wa1, vecs[k].wd0, vecs[k].wd1, vecs[k].ra0, vecs[k].ra1, 1'b0);
      lat_q.push_back(vecs[k].l0);
      #2;
      check($sformatf("v%0d d0", k), rd_d[7:0], vecs[k].d0);
      check($sformatf("v%0d d1", k), rd_d[15:8], vecs[k].d1);
      check($sformatf("v%0d nobypass", k), rd_nb[7:0], vecs[k].nb0);
      check($sformatf("v%0d zero", k), rd_z[7:0], vecs[k].z0);
      if (k > 0) check($sformatf("v%0d latency", k - 1), rd_l[7:0], lat_q.pop_front());
    end
    drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
    #2;
    if (lat_q.size() == 1) check("v10 latency", rd_l[7:0], lat_q.pop_front());
    else check("latency queue depth", 8'(lat_q.size()), 8'd1);
    for (int a = 0; a < 4; a++)
      drive(2'b11, 3'(2*a), 3'(2*a+1), 8'hFF, 8'hFF, 3'd0, 3'd0, 1'b0);
    drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      drive(c == 3 ? 2'b11 : 2'b00, 3'd5, 3'd1, 8'h33, 8'h33, 3'd5, 3'd1, c == 4);
      #2;
      if (!bz_d) break;
      n++;
      if (c == 3) begin
        check("sweep unswept addr5", rd_d[7:0], 8'hFF);
        check("sweep swept addr1 no bypass", rd_d[15:8], 8'h00);
      end
    end
    check("busy cycle count", 8'(n), 8'd8);
    for (int a = 0; a < 4; a++) begin
      drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'(2*a), 3'(2*a+1), 1'b0);
      #2;
      check($sformatf("post clear addr%0d", 2*a), rd_d[7:0], 8'h00);
      check($sformatf("post clear addr%0d", 2*a+1), rd_d[15:8], 8'h00);
    end
    drive(2'b01, 3'd5, 3'd0, 8'hAA, 8'h00, 3'd5, 3'd0, 1'b1);
    drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd5, 3'd0, 1'b0);
    #2;
    check("clear busy started", {7'd0, bz_d}, 8'h01);
    check("clear busy zero cfg", {7'd0, bz_z}, 8'h01);
    check("write with clear_req committed", rd_d[7:0], 8'hAA);
    #1 rst_n = 1'b0;
    #1;
    check("reset aborts busy", {7'd0, bz_d}, 8'h00);
    check("reset aborts busy zero cfg", {7'd0, bz_z}, 8'h00);
    check("reset clears addr5", rd_d[7:0], 8'h00);
    check("reset clears lat rd", rd_l[7:0], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 3'd5, 3'd0, 1'b0);
    #2;
    check("idle after reset", {7'd0, bz_d}, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
